// File: rtl/spi_frame_sequencer.sv
// Frames the SPI byte stream into sync + 7-byte RGBW command frames.
// Each payload byte is strobed to staging, and the frame commit is deferred to a PWM period boundary.
module spi_frame_sequencer #(
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter int unsigned PAYLOAD_BYTES  = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 11
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clk_half,
  input  logic       i_rdy,
  input  logic [7:0] i_buff_rx_spi,
  input  logic       i_pwm_wrap,
  output logic       o_load_en,
  output logic [2:0] o_byte_idx,
  output logic [7:0] o_data_out,
  output logic       o_commit,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    RECV      = 2'd1,
    WAIT_WRAP = 2'd2
  } state_t;

  localparam logic [2:0]      LAST_IDX = 3'(PAYLOAD_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  logic [2:0]      r_idx;
  logic [TO_W-1:0] r_to;
  logic            r_rdy_q;
  logic            r_rdy_qq;
  logic            r_load_en;
  logic [2:0]      r_byte_idx;
  logic [7:0]      r_data_out;
  logic            r_commit;
  logic            r_frame_err;

  state_t          w_state_n;
  logic [2:0]      w_idx_n;
  logic [TO_W-1:0] w_to_n;
  logic            w_load_n;
  logic [2:0]      w_byte_idx_n;
  logic [7:0]      w_data_n;
  logic            w_commit_n;
  logic            w_err_n;
  logic            w_en;
  logic            w_byte_evt;
  logic            w_is_sync;

  assign w_en       = ~i_clk_half;
  assign w_byte_evt = w_en & r_rdy_q & ~r_rdy_qq;
  assign w_is_sync  = (i_buff_rx_spi == SYNC_BYTE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= HUNT;
      r_idx       <= '0;
      r_to        <= '0;
      r_rdy_q     <= 1'b0;
      r_rdy_qq    <= 1'b0;
      r_load_en   <= 1'b0;
      r_byte_idx  <= '0;
      r_data_out  <= '0;
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_en) begin
        r_rdy_q  <= i_rdy;
        r_rdy_qq <= r_rdy_q;
      end
      r_state     <= w_state_n;
      r_idx       <= w_idx_n;
      r_to        <= w_to_n;
      r_load_en   <= w_load_n;
      r_byte_idx  <= w_byte_idx_n;
      r_data_out  <= w_data_n;
      r_commit    <= w_commit_n;
      r_frame_err <= w_err_n;
    end
  end

  // Pulses default low; WAIT_WRAP watches pwm_wrap on every clk so a one-clk wrap is never missed.
  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_to_n       = r_to;
    w_load_n     = 1'b0;
    w_byte_idx_n = r_byte_idx;
    w_data_n     = r_data_out;
    w_commit_n   = 1'b0;
    w_err_n      = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (w_byte_evt && w_is_sync) begin
          w_state_n = RECV;
          w_idx_n   = '0;
          w_to_n    = '0;
        end
      end
      RECV: begin
        if (w_byte_evt) begin
          w_load_n     = 1'b1;
          w_byte_idx_n = r_idx;
          w_data_n     = i_buff_rx_spi;
          w_to_n       = '0;
          if (r_idx == LAST_IDX) begin
            w_state_n = WAIT_WRAP;
          end else begin
            w_idx_n = r_idx + 3'd1;
          end
        end else if (w_en) begin
          if (r_to == TO_LAST) begin
            w_err_n   = 1'b1;
            w_state_n = HUNT;
            w_idx_n   = '0;
            w_to_n    = '0;
          end else begin
            w_to_n = r_to + 1'b1;
          end
        end
      end
      WAIT_WRAP: begin
        if (i_pwm_wrap || w_byte_evt) begin
          w_commit_n = 1'b1;
          w_state_n  = HUNT;
          // A byte arriving here commits early and is then treated as a fresh hunt byte.
          if (w_byte_evt && w_is_sync) begin
            w_state_n = RECV;
            w_idx_n   = '0;
            w_to_n    = '0;
          end
        end
      end
      default: begin
        w_state_n = HUNT;
        w_idx_n   = '0;
        w_to_n    = '0;
      end
    endcase
  end

  assign o_load_en   = r_load_en;
  assign o_byte_idx  = r_byte_idx;
  assign o_data_out  = r_data_out;
  assign o_commit    = r_commit;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != HUNT);

endmodule
